// File: rtl/alu_sequencer.sv
// Microprogram sequencer driving a 4-bit ALU: 16-entry instruction store, PC and accumulator.
// Optional single-step gating of ISSUE is enabled by defining ALU_SEQ_STEP_EN.
module alu_sequencer #(
   parameter int unsigned PROG_DEPTH = 16
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [8:0] prog_wdata,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] OPC4,
   output logic [3:0] Ain,
   output logic [3:0] Bin,
   input  logic [3:0] Aout,
   input  logic       Z,
   output logic [3:0] acc,
   output logic       zero,
   output logic       out_valid,
   output logic [3:0] out_data
`ifdef ALU_SEQ_STEP_EN
   ,
   input  logic       step
`endif
);

   localparam int unsigned AW      = 4;
   localparam int unsigned DW      = 4;
   localparam int unsigned WW      = 9;
   localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);
   localparam logic [DW-1:0] OP_STORE = 4'b0011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pc, pc_d;
   logic [DW-1:0]   acc_d, opc_d, ain_d, bin_d, out_data_d;
   logic            zero_d, out_valid_d, busy_d, done_d;
   logic [WW-1:0]   word;
   logic [WW-1:0]   mem [PROG_DEPTH];

   // Instruction store: not reset, writable only while idle.
   always_ff @(posedge Clk) begin
      if (prog_we && state_q == S_IDLE) begin
         mem[prog_addr] <= prog_wdata;
      end
   end

   assign word = mem[pc];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc;
      acc_d       = acc;
      zero_d      = zero;
      opc_d       = OPC4;
      ain_d       = Ain;
      bin_d       = Bin;
      out_valid_d = 1'b0;
      out_data_d  = out_data;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (word[8]) begin
               state_d = S_DONE;
            end else begin
               opc_d   = word[7:4];
               bin_d   = word[3:0];
               ain_d   = acc;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef ALU_SEQ_STEP_EN
            if (step) begin
               state_d = S_CAPTURE;
            end
`else
            state_d = S_CAPTURE;
`endif
         end
         S_CAPTURE: begin
            acc_d  = Aout;
            zero_d = Z;
            if (OPC4 == OP_STORE) begin
               out_valid_d = 1'b1;
               out_data_d  = Aout;
            end
            // The PC never wraps; finishing the last slot ends the program.
            if (pc == LAST_PC) begin
               state_d = S_DONE;
            end else begin
               pc_d    = pc + AW'(1);
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // Registered datapath and status outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc        <= '0;
         acc       <= '0;
         zero      <= 1'b0;
         OPC4      <= '0;
         Ain       <= '0;
         Bin       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         pc        <= pc_d;
         acc       <= acc_d;
         zero      <= zero_d;
         OPC4      <= opc_d;
         Ain       <= ain_d;
         Bin       <= bin_d;
         busy      <= busy_d;
         done      <= done_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural registered ALU.
// Step-mode scenario is built only when ALU_SEQ_STEP_EN is defined.
module tb_alu_sequencer;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [8:0] prog_wdata;
   logic       start;
   logic       busy, done;
   logic [3:0] OPC4, Ain, Bin;
   logic [3:0] Aout;
   logic       Z;
   logic [3:0] acc;
   logic       zero;
   logic       out_valid;
   logic [3:0] out_data;
`ifdef ALU_SEQ_STEP_EN
   logic       step;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   alu_sequencer #(.PROG_DEPTH(16)) dut (
      .Clk(Clk), .Rst(Rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .start(start), .busy(busy), .done(done),
      .OPC4(OPC4), .Ain(Ain), .Bin(Bin), .Aout(Aout), .Z(Z), .acc(acc),
      .zero(zero), .out_valid(out_valid), .out_data(out_data)
`ifdef ALU_SEQ_STEP_EN
      , .step(step)
`endif
   );

   function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      casez (op)
         4'b0000: r = b;
         4'b0001: r = a + b;
         4'b0010: r = a - b;
         4'b0011: r = a;
         4'b0100: r = 4'd0;
         4'b0101: r = a & b;
         4'b0110: r = a | b;
         4'b0111: r = ~a;
         4'b10??: r = a << 2;
         default: r = a >> 2;
      endcase
      return r;
   endfunction

   // Behavioural ALU with one-cycle registered result.
   always @(posedge Clk) begin
      Aout <= alu_f(OPC4, Ain, Bin);
      Z    <= (alu_f(OPC4, Ain, Bin) == 4'd0);
   end

   task automatic load(input logic [3:0] a, input logic [8:0] d);
      @(negedge Clk);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      @(negedge Clk);
      prog_we = 1'b0;
   endtask

   // Launch a program and collect observations until done (cycle 1 = period after the start edge).
   task automatic run_prog(input logic we0, input logic [8:0] wd0, input int poke_cyc,
                           output int done_cyc, output int busy_cnt, output int ov_cnt,
                           output logic [3:0] ov_data, output logic [3:0] opc5, output logic [3:0] ain5);
      int cyc;
      done_cyc = -1; busy_cnt = 0; ov_cnt = 0; ov_data = 4'hx; opc5 = 4'hx; ain5 = 4'hx;
      @(negedge Clk);
      start = 1'b1;
      if (we0) begin
         prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = wd0;
      end
      @(negedge Clk);
      start = 1'b0; prog_we = 1'b0;
      cyc = 1;
      while (cyc <= 200) begin
         if (cyc == poke_cyc) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 9'h100;
         end else if (cyc == poke_cyc + 1) begin
            start = 1'b0; prog_we = 1'b0;
         end
         if (busy) busy_cnt++;
         if (out_valid) begin
            ov_cnt++; ov_data = out_data;
         end
         if (cyc == 5) begin
            opc5 = OPC4; ain5 = Ain;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(negedge Clk);
         cyc++;
      end
      start = 1'b0; prog_we = 1'b0;
   endtask

   task automatic load_store_prog();
      load(4'd0, 9'h005);
      load(4'd1, 9'h013);
      load(4'd2, 9'h030);
      load(4'd3, 9'h100);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      checks++;
      if ({busy, done, out_valid, zero} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got=%b want=0000", {busy, done, out_valid, zero});
      end
      checks++;
      if ({acc, OPC4, Ain, Bin, out_data} !== 20'h0) begin
         failures++; $display("FAIL reset_data got=%h want=00000", {acc, OPC4, Ain, Bin, out_data});
      end
      Rst = 1'b0;
   endtask

   task automatic test_store_prog();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      load_store_prog();
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 11) begin failures++; $display("FAIL store_done_cycle got=%0d want=11", dc); end
      checks++;
      if (bc !== 10) begin failures++; $display("FAIL store_busy_cycles got=%0d want=10", bc); end
      checks++;
      if (oc !== 1 || od !== 4'd8) begin
         failures++; $display("FAIL store_out got=%0d/%h want=1/8", oc, od);
      end
      checks++;
      if (acc !== 4'd8 || zero !== 1'b0) begin
         failures++; $display("FAIL store_acc got=%h/%b want=8/0", acc, zero);
      end
   endtask

   task automatic test_zero_flag();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      load(4'd0, 9'h003);
      load(4'd1, 9'h023);
      load(4'd2, 9'h100);
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 8) begin failures++; $display("FAIL zero_done_cycle got=%0d want=8", dc); end
      checks++;
      if (acc !== 4'd0 || zero !== 1'b1) begin
         failures++; $display("FAIL zero_acc got=%h/%b want=0/1", acc, zero);
      end
      checks++;
      if (oc !== 0) begin failures++; $display("FAIL zero_no_out got=%0d want=0", oc); end
   endtask

   task automatic test_wrap_shift();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      load(4'd0, 9'h00F);
      load(4'd1, 9'h011);
      load(4'd2, 9'h100);
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (acc !== 4'd0 || zero !== 1'b1) begin
         failures++; $display("FAIL wrap_acc got=%h/%b want=0/1", acc, zero);
      end
      load(4'd0, 9'h003);
      load(4'd1, 9'h080);
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (acc !== 4'hC || zero !== 1'b0) begin
         failures++; $display("FAIL shl_acc got=%h/%b want=c/0", acc, zero);
      end
      checks++;
      if (o5 !== 4'h8 || a5 !== 4'h3) begin
         failures++; $display("FAIL shl_issue_ops got=%h/%h want=8/3", o5, a5);
      end
   endtask

   task automatic test_rst_mid();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      load_store_prog();
      @(negedge Clk); start = 1'b1;
      @(negedge Clk); start = 1'b0;
      repeat (4) @(negedge Clk);
      checks++;
      if (acc !== 4'd5 || OPC4 !== 4'h1 || Bin !== 4'h3) begin
         failures++; $display("FAIL rst_mid_pre got=%h/%h/%h want=5/1/3", acc, OPC4, Bin);
      end
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      checks++;
      if ({busy, done, out_valid, zero, acc, OPC4, Ain, Bin, out_data} !== 24'h0) begin
         failures++;
         $display("FAIL rst_mid_clear got=%h want=000000", {busy, done, out_valid, zero, acc, OPC4, Ain, Bin, out_data});
      end
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 11 || od !== 4'd8 || acc !== 4'd8) begin
         failures++; $display("FAIL rst_mid_rerun got=%0d/%h/%h want=11/8/8", dc, od, acc);
      end
   endtask

   task automatic test_ignore_busy();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      run_prog(1'b0, 9'h0, 4, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 11 || oc !== 1 || od !== 4'd8 || acc !== 4'd8) begin
         failures++; $display("FAIL busy_ignore got=%0d/%0d/%h/%h want=11/1/8/8", dc, oc, od, acc);
      end
      repeat (3) @(negedge Clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL busy_no_restart got=%b want=0", busy); end
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 11 || od !== 4'd8) begin
         failures++; $display("FAIL busy_store_intact got=%0d/%h want=11/8", dc, od);
      end
   endtask

   task automatic test_back_to_back();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 11 || bc !== 10 || od !== 4'd8) begin
         failures++; $display("FAIL b2b got=%0d/%0d/%h want=11/10/8", dc, bc, od);
      end
   endtask

   task automatic test_write_start();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      run_prog(1'b1, 9'h100, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 2 || bc !== 1) begin
         failures++; $display("FAIL write_start got=%0d/%0d want=2/1", dc, bc);
      end
      checks++;
      if (acc !== 4'd8) begin failures++; $display("FAIL write_start_acc got=%h want=8", acc); end
   endtask

   task automatic test_pc_end();
      int dc, bc, oc; logic [3:0] od, o5, a5;
      load(4'd0, 9'h000);
      for (int i = 1; i < 16; i++) load(4'(i), 9'h011);
      run_prog(1'b0, 9'h0, -10, dc, bc, oc, od, o5, a5);
      checks++;
      if (dc !== 49 || bc !== 48) begin
         failures++; $display("FAIL pc_end got=%0d/%0d want=49/48", dc, bc);
      end
      checks++;
      if (acc !== 4'hF || zero !== 1'b0) begin
         failures++; $display("FAIL pc_end_acc got=%h/%b want=f/0", acc, zero);
      end
   endtask

`ifdef ALU_SEQ_STEP_EN
   task automatic test_step();
      logic [3:0] a0;
      int dc;
      load(4'd0, 9'h005);
      load(4'd1, 9'h100);
      a0 = acc;
      step = 1'b0;
      @(negedge Clk); start = 1'b1;
      @(negedge Clk); start = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (OPC4 !== 4'h0 || Bin !== 4'h5 || Ain !== a0 || acc !== a0) begin
            failures++; $display("FAIL step_hold got=%h/%h/%h/%h want=0/5/%h/%h", OPC4, Bin, Ain, acc, a0, a0);
         end
         if (i < 4) @(negedge Clk);
      end
      step = 1'b1;
      @(negedge Clk);
      checks++;
      if (acc !== a0) begin failures++; $display("FAIL step_capture_pre got=%h want=%h", acc, a0); end
      @(negedge Clk);
      checks++;
      if (acc !== 4'd5) begin failures++; $display("FAIL step_capture got=%h want=5", acc); end
      dc = 0;
      while (!done && dc < 10) begin @(negedge Clk); dc++; end
      checks++;
      if (dc !== 1) begin failures++; $display("FAIL step_done got=%0d want=1", dc); end
   endtask
`endif

   initial begin
      Rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; start = 1'b0;
`ifdef ALU_SEQ_STEP_EN
      step = 1'b1;
`endif
      test_reset();
      test_store_prog();
      test_zero_flag();
      test_wrap_shift();
      test_rst_mid();
      test_ignore_busy();
      test_back_to_back();
      test_write_start();
      test_pc_end();
`ifdef ALU_SEQ_STEP_EN
      test_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microprogram sequencer that drives the 4-bit ALU's opcode/operand inputs and consumes its registered result and zero flag. It holds a 16-entry instruction store, a program counter and a 4-bit accumulator. It fetches each instruction, issues the opcode and operands to the ALU, waits out the ALU's one-cycle result latency, then writes the result back. It sits between the host/test controller and the ALU, acting as the initiator for the ALU's opcode interface.

## Interface
Parameters:
- PROG_DEPTH, 16, instruction store entries (address width fixed at 4)

Ports:
- Clk  in  1  system clock, all logic on posedge
- Rst  in  1  synchronous, active-high reset
- prog_we  in  1  instruction-store write enable
- prog_addr  in  4  instruction-store write address
- prog_wdata  in  9  instruction word: [8] HALT, [7:4] opcode, [3:0] immediate
- start  in  1  begin execution at address 0
- busy  out  1  high from first FETCH through last CAPTURE
- done  out  1  one-cycle pulse at program end
- OPC4  out  4  opcode to ALU
- Ain  out  4  accumulator value to ALU
- Bin  out  4  immediate to ALU
- Aout  in  4  ALU registered result
- Z  in  1  ALU zero flag
- acc  out  4  accumulator
- zero  out  1  captured Z of last executed instruction
- out_valid  out  1  one-cycle pulse on store opcode (0011)
- out_data  out  4  result captured with out_valid
- step  in  1  present only with ALU_SEQ_STEP_EN

## Operation
- States: IDLE, FETCH, ISSUE, CAPTURE, DONE.
- IDLE: `start`=1 -> `pc`=0, then FETCH. `prog_we` is accepted only in IDLE and is ignored in all other states.
- FETCH: read word at `pc`. If HALT=1 -> DONE, and nothing is issued to the ALU. Otherwise register OPC4=[7:4], Bin=[3:0], Ain=`acc` -> ISSUE.
- ISSUE: OPC4/Ain/Bin are held stable. The ALU samples them at the closing edge -> CAPTURE.
- CAPTURE: `Aout`/`Z` are valid. At the closing edge:
  - `acc`<=`Aout` and `zero`<=`Z`.
  - If the opcode is 0011, `out_valid`=1 and `out_data`=`Aout` for the following cycle.
  - If `pc`==15 -> DONE. Otherwise `pc`<=`pc`+1 and -> FETCH.
- DONE: `done`=1 for one cycle -> IDLE. `acc`/`zero` hold until the next `start` or `Rst`.
- Opcode meanings are the ALU's:
  - 0000 load Bin
  - 0001 add
  - 0010 sub
  - 0011 store
  - 0100 clear
  - 0101 and
  - 0110 or
  - 0111 not A
  - 10xx SHL by 2
  - 11xx SHR by 2
- The sequencer does not interpret opcodes except 0011.
- Arithmetic is modulo 16 and performed in the ALU. Cout is not consumed.
- `start` outside IDLE is ignored.
- `start` and `prog_we` in the same IDLE cycle: the write lands first, and execution sees the new word.
- `pc` never wraps: finishing address 15 without HALT ends the program.
- Instruction store is not reset; its contents survive `Rst`.

## Timing
- Reset values: state=IDLE, `pc`=0, `acc`=0, `zero`=0, OPC4=Ain=Bin=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0.
- `Rst` mid-program: all of the above apply at the next edge. Any in-flight ALU result is discarded.
- Each non-HALT instruction takes 3 cycles (FETCH, ISSUE, CAPTURE).
- With `start` sampled at edge 0 and N instructions before a HALT:
  - `done` is high during cycle 3N+2.
  - `busy` is high during cycles 1..3N+1.
- Back-to-back: `start` may be re-asserted in the cycle after `done`.

## Configuration
- `ALU_SEQ_STEP_EN` defined:
  - Adds the `step` input.
  - ISSUE holds its outputs and remains in ISSUE until `step`=1; it exits at the edge where `step` is sampled high.
  - Each instruction therefore takes ≥3 cycles.
- Undefined: no `step` port, and ISSUE always lasts exactly 1 cycle.

## Test plan
- Load [0]=0x005, [1]=0x013, [2]=0x030, [3]=0x100, then pulse `start` -> `out_valid` with `out_data`=8; `done` at cycle 11; `acc`=8, `zero`=0.
- Program lw 3, sub 3, HALT -> `acc`=0, `zero`=1; `done` at cycle 8.
- Program lw 0xF, add 1, then lw 3, SHL (0x80) -> `acc`=0 then `acc`=0xC. OPC4 is observed at the ALU only in ISSUE cycles.
- Assert `Rst` during the second instruction's ISSUE -> all outputs 0 next cycle. Re-`start` reruns the stored program unchanged.
- `start` pulse and `prog_we` to [0] while `busy` -> both ignored; the run completes with the original results.
- With `ALU_SEQ_STEP_EN`: hold `step`=0 for 5 cycles in ISSUE -> OPC4/Ain/Bin stable and `acc` unchanged. `step`=1 -> CAPTURE next cycle.
